serial_debug_node: RTL and testbench

Store-and-forward node on the serial debug chain, placed directly downstream of the UART debug bridge (or of another node). It receives one frame of BITS+16 bits on its upstream serial clock/data pair and decodes the direction and address fields. On an address match it either latches write data onto a local output bus or substitutes local read data into the frame. It then retransmits the frame downstream using the same wire protocol.

---
 rtl/serial_debug_node.sv | 157 +++++++++++++++
 tb/tb_serial_debug_node.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_debug_node.sv
// Store-and-forward node on the serial debug chain: receives a BITS+16 frame,
// performs the addressed write/read locally, then retransmits it downstream.
module serial_debug_node #(
    parameter int unsigned BITS      = 128,
    parameter logic [14:0] NODE_ADDR = 15'h0001,
    parameter int unsigned ENABLE    = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [7:0]      prescaler,
    input  logic            debug_rx_data,
    input  logic            debug_rx_clk,
    output logic            debug_tx_data,
    output logic            debug_tx_clk,
    input  logic [BITS-1:0] debug_in,
    output logic [BITS-1:0] debug_out,
    output logic            debug_out_valid,
    output logic            debug_in_strobe,
    output logic            overrun
);
    localparam int unsigned F     = BITS + 16;
    localparam int unsigned CNT_W = $clog2(F + 1);
    localparam logic [14:0] BCAST = 15'h7FFF;

    typedef enum logic [1:0] {S_RX, S_DECODE, S_TX_LOW, S_TX_HIGH} state_t;

    state_t            state_q, state_d;
    logic [3:0]        clk_pipe_q;
    logic [2:0]        data_pipe_q;
    logic [F-1:0]      frame_q, frame_d;
    logic [CNT_W-1:0]  bitcnt_q, bitcnt_d;
    logic [7:0]        pcnt_q, pcnt_d;
    logic              tx_clk_q, tx_clk_d;
    logic              tx_data_q, tx_data_d;
    logic [BITS-1:0]   out_q, out_d;
    logic              out_vld_q, out_vld_d;
    logic              strobe_q, strobe_d;
    logic              overrun_q, overrun_d;

    logic              rx_rise;
    logic              rx_bit;
    logic [7:0]        p_val;
    logic              dir;
    logic [14:0]       addr;

    assign rx_rise = ~clk_pipe_q[3] & clk_pipe_q[2];
    assign rx_bit  = data_pipe_q[2];
    assign p_val   = (prescaler == 8'd0) ? 8'd1 : prescaler;
    assign dir     = frame_q[F-1];
    assign addr    = frame_q[F-2 -: 15];

    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        bitcnt_d  = bitcnt_q;
        pcnt_d    = pcnt_q;
        tx_clk_d  = tx_clk_q;
        tx_data_d = tx_data_q;
        out_d     = out_q;
        out_vld_d = 1'b0;
        strobe_d  = 1'b0;
        // Edges arriving while busy are dropped; only the sticky flag records them.
        overrun_d = overrun_q | (rx_rise && (state_q != S_RX));
        case (state_q)
            S_RX: begin
                if (rx_rise) begin
                    frame_d  = {frame_q[F-2:0], rx_bit};
                    bitcnt_d = bitcnt_q + 1'b1;
                    if (bitcnt_q == CNT_W'(F - 1)) begin
                        state_d = S_DECODE;
                    end
                end
            end
            S_DECODE: begin
                if (dir && ((addr == NODE_ADDR) || (addr == BCAST))) begin
                    out_d     = frame_q[BITS-1:0];
                    out_vld_d = 1'b1;
                end
                if (!dir && (addr == NODE_ADDR)) begin
                    frame_d[BITS-1:0] = debug_in;
                    strobe_d          = 1'b1;
                end
                bitcnt_d  = CNT_W'(F);
                pcnt_d    = p_val;
                tx_clk_d  = 1'b0;
                tx_data_d = frame_q[F-1];
                state_d   = S_TX_LOW;
            end
            S_TX_LOW: begin
                if (pcnt_q <= 8'd1) begin
                    pcnt_d   = p_val;
                    tx_clk_d = 1'b1;
                    state_d  = S_TX_HIGH;
                end else begin
                    pcnt_d = pcnt_q - 8'd1;
                end
            end
            S_TX_HIGH: begin
                if (pcnt_q <= 8'd1) begin
                    frame_d  = {frame_q[F-2:0], 1'b0};
                    bitcnt_d = bitcnt_q - 1'b1;
                    if (bitcnt_q == CNT_W'(1)) begin
                        state_d = S_RX;
                    end else begin
                        tx_clk_d  = 1'b0;
                        tx_data_d = frame_q[F-2];
                        pcnt_d    = p_val;
                        state_d   = S_TX_LOW;
                    end
                end else begin
                    pcnt_d = pcnt_q - 8'd1;
                end
            end
            default: state_d = S_RX;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_RX;
            clk_pipe_q  <= 4'hF;
            data_pipe_q <= 3'b000;
            bitcnt_q    <= '0;
            pcnt_q      <= 8'd0;
            tx_clk_q    <= 1'b1;
            tx_data_q   <= 1'b0;
            out_q       <= '0;
            out_vld_q   <= 1'b0;
            strobe_q    <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_pipe_q  <= {clk_pipe_q[2:0], debug_rx_clk};
            data_pipe_q <= {data_pipe_q[1:0], debug_rx_data};
            bitcnt_q    <= bitcnt_d;
            pcnt_q      <= pcnt_d;
            tx_clk_q    <= tx_clk_d;
            tx_data_q   <= tx_data_d;
            out_q       <= out_d;
            out_vld_q   <= out_vld_d;
            strobe_q    <= strobe_d;
            overrun_q   <= overrun_d;
        end
    end

    // The frame is fully rewritten by every reception, so it needs no reset.
    always_ff @(posedge clk) begin
        frame_q <= frame_d;
    end

    assign debug_tx_clk    = (ENABLE != 0) ? tx_clk_q  : debug_rx_clk;
    assign debug_tx_data   = (ENABLE != 0) ? tx_data_q : debug_rx_data;
    assign debug_out       = (ENABLE != 0) ? out_q     : '0;
    assign debug_out_valid = (ENABLE != 0) ? out_vld_q : 1'b0;
    assign debug_in_strobe = (ENABLE != 0) ? strobe_q  : 1'b0;
    assign overrun         = (ENABLE != 0) ? overrun_q : 1'b0;
endmodule

// File: tb/tb_serial_debug_node.sv
// Scoreboard bench for serial_debug_node: upstream frames are driven bit by bit,
// the downstream serial stream is reassembled and compared against queued frames.
module tb_serial_debug_node;
    localparam int BITS = 128;
    localparam int F    = BITS + 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [7:0]      prescaler = 8'd2;
    logic            rx_data = 1'b0;
    logic            rx_clk  = 1'b1;
    logic [BITS-1:0] din = 128'h0123456789ABCDEF0123456789ABCDEF;
    logic            tx_data, tx_clk, out_valid, in_strobe, ovr;
    logic [BITS-1:0] dout;

    logic            off_rx_data = 1'b0;
    logic            off_rx_clk  = 1'b1;
    logic            off_tx_data, off_tx_clk, off_valid, off_strobe, off_ovr;
    logic [BITS-1:0] off_dout;

    serial_debug_node #(.BITS(BITS), .NODE_ADDR(15'd5), .ENABLE(1)) dut (
        .clk(clk), .rst(rst), .prescaler(prescaler),
        .debug_rx_data(rx_data), .debug_rx_clk(rx_clk),
        .debug_tx_data(tx_data), .debug_tx_clk(tx_clk),
        .debug_in(din), .debug_out(dout), .debug_out_valid(out_valid),
        .debug_in_strobe(in_strobe), .overrun(ovr)
    );

    serial_debug_node #(.BITS(BITS), .NODE_ADDR(15'd5), .ENABLE(0)) dut_off (
        .clk(clk), .rst(rst), .prescaler(prescaler),
        .debug_rx_data(off_rx_data), .debug_rx_clk(off_rx_clk),
        .debug_tx_data(off_tx_data), .debug_tx_clk(off_tx_clk),
        .debug_in(din), .debug_out(off_dout), .debug_out_valid(off_valid),
        .debug_in_strobe(off_strobe), .overrun(off_ovr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [F-1:0] got, input logic [F-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [F-1:0] mk(input logic d, input logic [14:0] a, input logic [BITS-1:0] x);
        return {d, a, x};
    endfunction

    logic [F-1:0] expq[$];
    logic         prev_tx = 1'b1;
    logic [F-1:0] mon_frame = '0;
    int cyc = 0, last_rise = 0, mon_bits = 0, frames_done = 0;
    int pmin = 1000, pmax = 0, valid_cnt = 0, strobe_cnt = 0, exp_period = 4;

    always @(negedge clk) begin
        cyc++;
        if (out_valid) valid_cnt++;
        if (in_strobe) strobe_cnt++;
        if (rst) begin
            mon_bits = 0;
            prev_tx  = 1'b1;
            pmin     = 1000;
            pmax     = 0;
        end else begin
            if (!prev_tx && tx_clk) begin
                mon_frame = {mon_frame[F-2:0], tx_data};
                if (mon_bits > 0) begin
                    if (cyc - last_rise < pmin) pmin = cyc - last_rise;
                    if (cyc - last_rise > pmax) pmax = cyc - last_rise;
                end
                last_rise = cyc;
                mon_bits++;
                if (mon_bits == F) begin
                    if (expq.size() == 0) begin
                        check("unexpected_frame", expq.size(), 1);
                    end else begin
                        check("frame", mon_frame, expq.pop_front());
                        check("period_min", pmin, exp_period);
                        check("period_max", pmax, exp_period);
                    end
                    frames_done++;
                    mon_bits = 0;
                    pmin     = 1000;
                    pmax     = 0;
                end
            end
            prev_tx = tx_clk;
        end
    end

    task automatic drive_bits(input logic [F-1:0] fr, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            rx_clk  = 1'b0;
            rx_data = fr[F-1-i];
            repeat (4) @(posedge clk);
            #1 rx_clk = 1'b1;
            repeat (3) @(posedge clk);
        end
    endtask

    task automatic send(input logic [F-1:0] fr, input logic [F-1:0] exp, input bit inject);
        int target;
        target = frames_done + 1;
        expq.push_back(exp);
        drive_bits(fr, F);
        if (inject) begin
            repeat (20) @(posedge clk);
            #1 rx_clk = 1'b0;
            repeat (4) @(posedge clk);
            #1 rx_clk = 1'b1;
        end
        for (int k = 0; k < 4000 && frames_done < target; k++) @(posedge clk);
        check("tx_done", frames_done, target);
        repeat (4) @(posedge clk);
    endtask

    localparam logic [BITS-1:0] D1 = 128'hDEADBEEF_CAFEF00D_01234567_DEADBEEF;
    localparam logic [BITS-1:0] D2 = 128'h13579BDF_2468ACE0_0F0F0F0F_F0F0F0F1;
    localparam logic [BITS-1:0] D3 = 128'hA5A5A5A5_00000000_FFFFFFFF_5A5A5A5A;
    localparam logic [BITS-1:0] D55 = {16{8'h55}};

    initial begin
        int v0, s0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx_clk", tx_clk, 1);
        check("rst_tx_data", tx_data, 0);
        check("rst_out", dout, 0);
        check("rst_valid", out_valid, 0);
        check("rst_strobe", in_strobe, 0);
        check("rst_overrun", ovr, 0);
        @(posedge clk); #1 rst = 1'b0;

        v0 = valid_cnt; s0 = strobe_cnt;
        send(mk(1, 15'd5, D1), mk(1, 15'd5, D1), 0);
        check("wr_out", dout, D1);
        check("wr_valid", valid_cnt - v0, 1);
        check("wr_strobe", strobe_cnt - s0, 0);

        v0 = valid_cnt; s0 = strobe_cnt;
        send(mk(0, 15'd5, '0), mk(0, 15'd5, din), 0);
        check("rd_strobe", strobe_cnt - s0, 1);
        check("rd_valid", valid_cnt - v0, 0);
        check("rd_out", dout, D1);

        v0 = valid_cnt; s0 = strobe_cnt;
        send(mk(1, 15'd6, D2), mk(1, 15'd6, D2), 0);
        send(mk(0, 15'd6, D3), mk(0, 15'd6, D3), 0);
        check("miss_valid", valid_cnt - v0, 0);
        check("miss_strobe", strobe_cnt - s0, 0);
        check("miss_out", dout, D1);

        v0 = valid_cnt; s0 = strobe_cnt;
        send(mk(1, 15'h7FFF, D55), mk(1, 15'h7FFF, D55), 0);
        check("bc_wr_out", dout, D55);
        check("bc_wr_valid", valid_cnt - v0, 1);
        send(mk(0, 15'h7FFF, D3), mk(0, 15'h7FFF, D3), 0);
        check("bc_rd_strobe", strobe_cnt - s0, 0);
        check("pre_overrun", ovr, 0);

        send(mk(1, 15'd5, D2), mk(1, 15'd5, D2), 1);
        check("overrun_set", ovr, 1);
        check("ovr_out", dout, D2);

        drive_bits(mk(1, 15'd5, D3), 40);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_tx_clk", tx_clk, 1);
        check("mid_rst_tx_data", tx_data, 0);
        check("mid_rst_out", dout, 0);
        check("mid_rst_overrun", ovr, 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (4) @(posedge clk);

        v0 = valid_cnt;
        send(mk(1, 15'd5, D3), mk(1, 15'd5, D3), 0);
        check("post_rst_out", dout, D3);
        check("post_rst_valid", valid_cnt - v0, 1);

        prescaler = 8'd0;
        exp_period = 2;
        send(mk(0, 15'd9, D1), mk(0, 15'd9, D1), 0);
        prescaler = 8'd2;
        exp_period = 4;

        for (int i = 0; i < 4; i++) begin
            off_rx_clk  = i[0];
            off_rx_data = i[1];
            #1;
            check("pass_clk", off_tx_clk, i[0]);
            check("pass_data", off_tx_data, i[1]);
            @(posedge clk);
            #1;
        end
        off_rx_clk = 1'b1;
        @(negedge clk);
        check("off_out", off_dout, 0);
        check("off_valid", off_valid, 0);
        check("off_strobe", off_strobe, 0);
        check("off_overrun", off_ovr, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
